// File: rtl/i2s_rx_frame_ctrl_if.sv
// rtl/i2s_rx_frame_ctrl_if.sv - stereo frame stream between the I2S receive sequencer and the effects DSP
//
// Signals:
//   left_out, right_out  head frame samples (DATA_W each)
//   frame_valid          head frame present
//   frame_ready          consumer accepts the head frame
// Modports: master = frame producer, slave = frame consumer.
interface i2s_rx_frame_ctrl_if #(
    parameter int DATA_W = 24
) ();
    logic [DATA_W-1:0] left_out;
    logic [DATA_W-1:0] right_out;
    logic              frame_valid;
    logic              frame_ready;

    modport master (
        output left_out,
        output right_out,
        output frame_valid,
        input  frame_ready
    );

    modport slave (
        input  left_out,
        input  right_out,
        input  frame_valid,
        output frame_ready
    );
endinterface

// File: rtl/i2s_rx_frame_ctrl.sv
// rtl/i2s_rx_frame_ctrl.sv - I2S receive master: lrclk generation, L/R word pairing, 2-frame FWFT buffer
//
// Ports:
//   sclk          bit clock, all logic on posedge
//   rst           synchronous active-high reset
//   enable        run frame generation and capture
//   lrclk         word select, 0 = left half, 1 = right half
//   rx_data       word from the deserializer
//   rx_dvalid     deserializer valid level; rising edge marks a new word
//   sync_err      one-cycle pulse on a channel-order violation
//   overflow_cnt  saturating count of frames dropped on a full buffer
//   frm           frame stream to the DSP (left_out, right_out, frame_valid, frame_ready)
module i2s_rx_frame_ctrl #(
    parameter int DATA_W = 24,
    parameter int SLOT_W = 32,
    parameter int OVF_W  = 8
) (
    input  logic                 sclk,
    input  logic                 rst,
    input  logic                 enable,
    output logic                 lrclk,
    input  logic [DATA_W-1:0]    rx_data,
    input  logic                 rx_dvalid,
    output logic                 sync_err,
    output logic [OVF_W-1:0]     overflow_cnt,
    i2s_rx_frame_ctrl_if.master  frm
);
    localparam int CNT_W = $clog2(2 * SLOT_W);

    typedef enum logic {
        WAIT_L,
        WAIT_R
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic                dv_q;
    logic                evt;
    logic [DATA_W-1:0]   left_q;

    logic [2*DATA_W-1:0] mem [2];
    logic                wr_ptr;
    logic                rd_ptr;
    logic [1:0]          count;
    logic                push;
    logic                pop;
    logic                full;
    logic                do_push;

    // Frame counter and word select. lrclk is derived from the next count so
    // that it always reflects the half the counter is currently in.
    always_comb begin
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == CNT_W'(2 * SLOT_W - 1)) begin
            cnt_nxt = '0;
        end
    end

    always_ff @(posedge sclk) begin
        if (rst || !enable) begin
            cnt   <= '0;
            lrclk <= 1'b0;
        end else begin
            cnt   <= cnt_nxt;
            lrclk <= (cnt_nxt >= CNT_W'(SLOT_W));
        end
    end

    // dv_q resets high so a valid level already present at reset release is
    // not mistaken for a fresh word.
    assign evt = rx_dvalid & ~dv_q & enable;

    // Channel pairing FSM; the word is tagged by the lrclk half it arrives in.
    always_ff @(posedge sclk) begin
        if (rst) begin
            state    <= WAIT_L;
            left_q   <= '0;
            sync_err <= 1'b0;
            dv_q     <= 1'b1;
        end else begin
            dv_q     <= rx_dvalid;
            sync_err <= 1'b0;
            if (!enable) begin
                state  <= WAIT_L;
                left_q <= '0;
            end else if (evt) begin
                case (state)
                    WAIT_L: begin
                        if (!lrclk) begin
                            left_q <= rx_data;
                            state  <= WAIT_R;
                        end else begin
                            sync_err <= 1'b1;
                        end
                    end
                    WAIT_R: begin
                        if (!lrclk) begin
                            // A second left word replaces the stale one.
                            left_q   <= rx_data;
                            sync_err <= 1'b1;
                        end else begin
                            state <= WAIT_L;
                        end
                    end
                    default: state <= WAIT_L;
                endcase
            end
        end
    end

    // Two-entry first-word-fall-through frame buffer.
    assign push    = evt & lrclk & (state == WAIT_R);
    assign full    = (count == 2'd2);
    assign pop     = (count != 2'd0) & frm.frame_ready;
    // A push into a full buffer is still accepted when the head leaves
    // in the same cycle.
    assign do_push = push & (~full | pop);

    always_ff @(posedge sclk) begin
        if (rst) begin
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            count        <= 2'd0;
            overflow_cnt <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= {left_q, rx_data};
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, pop};
            if (push && full && !pop && (overflow_cnt != '1)) begin
                overflow_cnt <= overflow_cnt + OVF_W'(1);
            end
        end
    end

    assign frm.frame_valid = (count != 2'd0);
    assign frm.left_out    = frm.frame_valid ? mem[rd_ptr][2*DATA_W-1:DATA_W] : '0;
    assign frm.right_out   = frm.frame_valid ? mem[rd_ptr][DATA_W-1:0]        : '0;
endmodule

// File: tb/tb_i2s_rx_frame_ctrl.sv
// tb/tb_i2s_rx_frame_ctrl.sv - self-checking bench for i2s_rx_frame_ctrl
module tb_i2s_rx_frame_ctrl;
    localparam int DATA_W = 24;
    localparam int SLOT_W = 32;
    localparam int OVF_W  = 8;
    localparam int OVF_MAX = (1 << OVF_W) - 1;

    logic              sclk = 1'b0;
    logic              rst;
    logic              enable;
    logic              lrclk;
    logic [DATA_W-1:0] rx_data;
    logic              rx_dvalid;
    logic              sync_err;
    logic [OVF_W-1:0]  overflow_cnt;

    i2s_rx_frame_ctrl_if #(.DATA_W(DATA_W)) frm_if ();

    i2s_rx_frame_ctrl #(
        .DATA_W(DATA_W),
        .SLOT_W(SLOT_W),
        .OVF_W (OVF_W)
    ) dut (
        .sclk        (sclk),
        .rst         (rst),
        .enable      (enable),
        .lrclk       (lrclk),
        .rx_data     (rx_data),
        .rx_dvalid   (rx_dvalid),
        .sync_err    (sync_err),
        .overflow_cnt(overflow_cnt),
        .frm         (frm_if)
    );

    always #5 sclk = ~sclk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: position in the frame, edge detector, pending left word, frame queue.
    int                 m_k;
    bit                 m_dvq;
    bit                 m_have;
    logic [DATA_W-1:0]  m_left;
    logic [2*DATA_W-1:0] m_q[$];
    int                 m_ovf;
    bit                 m_serr;

    typedef struct {
        bit                ch;
        logic [DATA_W-1:0] data;
        bit                rdy;
        bit                ev_rdy;
        bit                e_serr;
        bit                e_fv;
        logic [DATA_W-1:0] e_l;
        logic [DATA_W-1:0] e_r;
        int                e_ovf;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    task automatic model_reset();
        m_k    = 0;
        m_dvq  = 1'b1;
        m_have = 1'b0;
        m_left = '0;
        m_q.delete();
        m_ovf  = 0;
        m_serr = 1'b0;
    endtask

    // One sclk cycle: advance the model on the current inputs, clock the DUT, compare.
    task automatic tick();
        bit lr, evt, pop, push;
        int sz;
        logic [2*DATA_W-1:0] f;
        lr   = (m_k >= SLOT_W);
        push = 1'b0;
        f    = '0;
        if (rst) begin
            model_reset();
        end else begin
            evt    = rx_dvalid && !m_dvq && enable;
            sz     = m_q.size();
            pop    = (sz > 0) && frm_if.frame_ready;
            m_serr = 1'b0;
            if (!enable) begin
                m_have = 1'b0;
                m_left = '0;
            end else if (evt) begin
                if (!lr) begin
                    m_serr = m_have;
                    m_left = rx_data;
                    m_have = 1'b1;
                end else if (m_have) begin
                    push   = 1'b1;
                    f      = {m_left, rx_data};
                    m_have = 1'b0;
                end else begin
                    m_serr = 1'b1;
                end
            end
            if (pop) void'(m_q.pop_front());
            if (push) begin
                if (sz == 2 && !pop) begin
                    if (m_ovf < OVF_MAX) m_ovf++;
                end else begin
                    m_q.push_back(f);
                end
            end
            m_dvq = rx_dvalid;
            m_k   = enable ? (m_k + 1) % (2 * SLOT_W) : 0;
        end
        @(posedge sclk);
        #1;
        chk("lrclk", 64'(lrclk), 64'(m_k >= SLOT_W));
        chk("frame_valid", 64'(frm_if.frame_valid), 64'(m_q.size() > 0));
        chk("left_out", 64'(frm_if.left_out), 64'((m_q.size() > 0) ? m_q[0][2*DATA_W-1:DATA_W] : '0));
        chk("right_out", 64'(frm_if.right_out), 64'((m_q.size() > 0) ? m_q[0][DATA_W-1:0] : '0));
        chk("sync_err", 64'(sync_err), 64'(m_serr));
        chk("overflow_cnt", 64'(overflow_cnt), 64'(m_ovf));
    endtask

    // Release rx_dvalid for a cycle, wait for the requested half, then raise it with the word.
    task automatic send_word(input bit ch, input logic [DATA_W-1:0] d, input bit rdy, input bit ev_rdy);
        int n;
        rx_dvalid          = 1'b0;
        frm_if.frame_ready = rdy;
        tick();
        n = 0;
        while (lrclk !== ch && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) timeout("lrclk_wait");
        rx_data            = d;
        rx_dvalid          = 1'b1;
        frm_if.frame_ready = ev_rdy;
        tick();
        frm_if.frame_ready = rdy;
    endtask

    task automatic add_vec(input bit ch, input logic [DATA_W-1:0] d, input bit rdy, input bit ev_rdy,
                           input bit e_serr, input bit e_fv, input logic [DATA_W-1:0] e_l,
                           input logic [DATA_W-1:0] e_r, input int e_ovf);
        vec_t v;
        v.ch = ch; v.data = d; v.rdy = rdy; v.ev_rdy = ev_rdy;
        v.e_serr = e_serr; v.e_fv = e_fv; v.e_l = e_l; v.e_r = e_r; v.e_ovf = e_ovf;
        tbl.push_back(v);
    endtask

    task automatic measure_until(input bit level, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (lrclk !== level && n < 200);
    endtask

    initial begin
        int n;

        // Word-level vectors: channel, data, ready while waiting, ready on the event
        // cycle, then sync_err / head frame / overflow right after the event edge.
        add_vec(0, 24'h123456, 1, 1, 0, 0, 24'h000000, 24'h000000, 0);
        add_vec(1, 24'hABCDEF, 1, 1, 0, 1, 24'h123456, 24'hABCDEF, 0);
        add_vec(0, 24'h111111, 1, 0, 0, 0, 24'h000000, 24'h000000, 0);
        add_vec(1, 24'h222222, 0, 0, 0, 1, 24'h111111, 24'h222222, 0);
        add_vec(0, 24'h333333, 0, 0, 0, 1, 24'h111111, 24'h222222, 0);
        add_vec(1, 24'h444444, 0, 0, 0, 1, 24'h111111, 24'h222222, 0);
        add_vec(0, 24'h555555, 0, 0, 0, 1, 24'h111111, 24'h222222, 0);
        add_vec(1, 24'h666666, 0, 0, 0, 1, 24'h111111, 24'h222222, 1);

        rst = 1'b1; enable = 1'b0; rx_dvalid = 1'b0; rx_data = '0; frm_if.frame_ready = 1'b0;
        model_reset();
        tick();
        tick();
        chk("reset_lrclk", 64'(lrclk), 64'd0);
        chk("reset_frame_valid", 64'(frm_if.frame_valid), 64'd0);
        chk("reset_left_out", 64'(frm_if.left_out), 64'd0);
        chk("reset_overflow", 64'(overflow_cnt), 64'd0);

        // lrclk timing: 32 low, 32 high, 32 low; enable drop at count 40 restarts the left half.
        rst = 1'b0; enable = 1'b1;
        measure_until(1'b1, n); chk("lrclk_first_low", 64'(n), 64'(SLOT_W));
        measure_until(1'b0, n); chk("lrclk_high_run", 64'(n), 64'(SLOT_W));
        measure_until(1'b1, n); chk("lrclk_low_run", 64'(n), 64'(SLOT_W));
        n = 0;
        while (m_k != 40 && n < 200) begin tick(); n++; end
        if (n >= 200) timeout("count40_wait");
        enable = 1'b0;
        tick();
        chk("lrclk_after_disable", 64'(lrclk), 64'd0);
        enable = 1'b1;
        measure_until(1'b1, n); chk("lrclk_restart_low", 64'(n), 64'(SLOT_W));

        // Sample frame, backpressure and overflow.
        foreach (tbl[i]) begin
            send_word(tbl[i].ch, tbl[i].data, tbl[i].rdy, tbl[i].ev_rdy);
            chk($sformatf("vec%0d_sync_err", i), 64'(sync_err), 64'(tbl[i].e_serr));
            chk($sformatf("vec%0d_frame_valid", i), 64'(frm_if.frame_valid), 64'(tbl[i].e_fv));
            chk($sformatf("vec%0d_left", i), 64'(frm_if.left_out), 64'(tbl[i].e_l));
            chk($sformatf("vec%0d_right", i), 64'(frm_if.right_out), 64'(tbl[i].e_r));
            chk($sformatf("vec%0d_ovf", i), 64'(overflow_cnt), 64'(tbl[i].e_ovf));
        end
        frm_if.frame_ready = 1'b1;
        tick();
        chk("drain1_left", 64'(frm_if.left_out), 64'h333333);
        chk("drain1_right", 64'(frm_if.right_out), 64'h444444);
        tick();
        chk("drain2_empty", 64'(frm_if.frame_valid), 64'd0);

        // Full buffer with push and pop on the same edge.
        tbl.delete();
        add_vec(0, 24'hAAAAA1, 0, 0, 0, 0, 24'h000000, 24'h000000, 1);
        add_vec(1, 24'hBBBBB1, 0, 0, 0, 1, 24'hAAAAA1, 24'hBBBBB1, 1);
        add_vec(0, 24'hAAAAA2, 0, 0, 0, 1, 24'hAAAAA1, 24'hBBBBB1, 1);
        add_vec(1, 24'hBBBBB2, 0, 0, 0, 1, 24'hAAAAA1, 24'hBBBBB1, 1);
        add_vec(0, 24'hAAAAA3, 0, 0, 0, 1, 24'hAAAAA1, 24'hBBBBB1, 1);
        add_vec(1, 24'hBBBBB3, 0, 1, 0, 1, 24'hAAAAA2, 24'hBBBBB2, 1);
        foreach (tbl[i]) begin
            send_word(tbl[i].ch, tbl[i].data, tbl[i].rdy, tbl[i].ev_rdy);
            chk($sformatf("full%0d_frame_valid", i), 64'(frm_if.frame_valid), 64'(tbl[i].e_fv));
            chk($sformatf("full%0d_left", i), 64'(frm_if.left_out), 64'(tbl[i].e_l));
            chk($sformatf("full%0d_right", i), 64'(frm_if.right_out), 64'(tbl[i].e_r));
            chk($sformatf("full%0d_ovf", i), 64'(overflow_cnt), 64'(tbl[i].e_ovf));
        end
        frm_if.frame_ready = 1'b1;
        tick();
        chk("fulldrain_left", 64'(frm_if.left_out), 64'hAAAAA3);
        chk("fulldrain_right", 64'(frm_if.right_out), 64'hBBBBB3);
        tick();
        chk("fulldrain_empty", 64'(frm_if.frame_valid), 64'd0);

        // Channel-order errors, then a buffered frame left in place for the reset case.
        tbl.delete();
        add_vec(1, 24'h0000AA, 1, 1, 1, 0, 24'h000000, 24'h000000, 1);
        add_vec(0, 24'h000001, 1, 1, 0, 0, 24'h000000, 24'h000000, 1);
        add_vec(0, 24'h000002, 1, 1, 1, 0, 24'h000000, 24'h000000, 1);
        add_vec(1, 24'h000003, 1, 0, 0, 1, 24'h000002, 24'h000003, 1);
        add_vec(0, 24'h0A0A0A, 0, 0, 0, 1, 24'h000002, 24'h000003, 1);
        foreach (tbl[i]) begin
            send_word(tbl[i].ch, tbl[i].data, tbl[i].rdy, tbl[i].ev_rdy);
            chk($sformatf("sync%0d_sync_err", i), 64'(sync_err), 64'(tbl[i].e_serr));
            chk($sformatf("sync%0d_frame_valid", i), 64'(frm_if.frame_valid), 64'(tbl[i].e_fv));
            chk($sformatf("sync%0d_left", i), 64'(frm_if.left_out), 64'(tbl[i].e_l));
            chk($sformatf("sync%0d_right", i), 64'(frm_if.right_out), 64'(tbl[i].e_r));
        end

        // Reset mid-operation discards the buffered frame and the pending left word.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_frame_valid", 64'(frm_if.frame_valid), 64'd0);
        chk("midrst_ovf", 64'(overflow_cnt), 64'd0);
        send_word(1'b1, 24'h0B0B0B, 1'b0, 1'b0);
        chk("midrst_r_sync_err", 64'(sync_err), 64'd1);
        chk("midrst_r_no_frame", 64'(frm_if.frame_valid), 64'd0);

        // rx_dvalid high across reset release must not create a left word.
        rx_dvalid = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        send_word(1'b1, 24'h0C0C0C, 1'b0, 1'b0);
        chk("dvhigh_r_sync_err", 64'(sync_err), 64'd1);
        chk("dvhigh_no_frame", 64'(frm_if.frame_valid), 64'd0);

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            rst                = ($urandom_range(0, 399) == 0);
            enable             = ($urandom_range(0, 49) != 0);
            rx_dvalid          = ($urandom_range(0, 3) == 0);
            rx_data            = DATA_W'($urandom);
            frm_if.frame_ready = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/i2s_rx_frame_ctrl.md
Name: i2s_rx_frame_ctrl

Overview:
Master-mode sequencer for the I2S receive path. It generates lrclk for the codec and the deserializer from the sclk domain, and tags each completed 24-bit word from the deserializer as left or right. It pairs the words into stereo frames and buffers them in a 2-entry FIFO. The FIFO feeds the effects DSP through a valid/ready handshake, and the block reports overflow and channel-sync errors.

Parameters:
DATA_W, 24, sample width, equal to the deserializer word width
SLOT_W, 32, sclk cycles per channel half-frame (frame = 2*SLOT_W)
OVF_W, 8, width of the saturating overflow counter

Ports:
sclk  in  1  bit clock, all logic on posedge
rst  in  1  reset, synchronous, active-high
enable  in  1  1 = run frame generation and capture
lrclk  out  1  word select to codec/deserializer; 0 = left, 1 = right
rx_data  in  DATA_W  word from the deserializer
rx_dvalid  in  1  deserializer valid level; a rising edge marks a new word
left_out  out  DATA_W  left sample of the head frame
right_out  out  DATA_W  right sample of the head frame
frame_valid  out  1  FIFO non-empty
frame_ready  in  1  downstream accepts the head frame
sync_err  out  1  one-cycle pulse when a channel-order violation is detected
overflow_cnt  out  OVF_W  count of dropped frames, saturating

Behaviour:
Reset values:
- lrclk=0, bit counter=0, FSM=WAIT_L, left hold register=0.
- FIFO empty, so frame_valid=0; left_out/right_out=0.
- sync_err=0, overflow_cnt=0.
- dv_q=1, so a rx_dvalid already high at reset release does not create an event.

lrclk generation:
- Counter runs 0..2*SLOT_W-1 and wraps to 0.
- lrclk is registered: 0 while counter<SLOT_W, 1 otherwise.
- enable=0: counter held at 0 and lrclk=0.
- Deasserting enable mid-frame clears the counter on the next edge, with no completion of the current frame.

Word event:
- dv_q <= rx_dvalid every cycle.
- evt = rx_dvalid & ~dv_q & enable.
- On evt, rx_data is captured and tagged with the current lrclk value: L if 0, R if 1.

FSM (states WAIT_L, WAIT_R):
- WAIT_L, evt L: store left, go to WAIT_R.
- WAIT_L, evt R: discard word, pulse sync_err, stay in WAIT_L.
- WAIT_R, evt R: push {left, rx_data} into the FIFO, go to WAIT_L.
- WAIT_R, evt L: overwrite left, pulse sync_err, stay in WAIT_R.
- enable=0: go to WAIT_L and clear the left register.
- FIFO contents are retained with enable=0 and still drain.

FIFO, 2 entries, first-word-fall-through:
- frame_valid=1 whenever the FIFO count is greater than 0.
- left_out/right_out show the head entry. They hold their value while frame_valid=1 and frame_ready=0.
- A pop occurs on frame_valid & frame_ready.
- A pushed frame into an empty FIFO appears with frame_valid=1 on the cycle after the push edge (1 sclk latency).
- Push while full without a same-cycle pop: the new frame is dropped and overflow_cnt increments, saturating at 2^OVF_W-1. FIFO contents are unchanged.
- Push while full with a same-cycle pop: both happen, count stays 2, no overflow.
- Pop while empty: ignored.
- Pointers wrap modulo 2.

Reset mid-operation: all state returns to reset values on the next edge. Partial left words and buffered frames are discarded.

Test Plan:
- Run, sample words: enable=1, frame_ready=1. Word at lrclk=0 = 0x123456, then lrclk=1 = 0xABCDEF → one frame, left_out=0x123456, right_out=0xABCDEF, frame_valid high for 1 cycle. sync_err never set; overflow_cnt=0.
- lrclk timing: enable=1, SLOT_W=32 → lrclk low 32 / high 32 sclk, period 64. enable dropped at count 40 → lrclk=0 next cycle; restart begins a fresh left half.
- Backpressure and overflow: frame_ready=0, push 3 frames (L1/R1, L2/R2, L3/R3) → frame_valid=1 with head=L1/R1 held, overflow_cnt=1. Then frame_ready=1 → pops L1/R1, then L2/R2, then frame_valid=0.
- Full with simultaneous push/pop: FIFO full, frame_ready=1 in the same cycle as the R word → no overflow_cnt increment, count stays 2.
- Sync errors: R word while in WAIT_L → sync_err pulse, no frame. Then L=0x000001, L=0x000002, R=0x000003 → one sync_err pulse and frame {0x000002, 0x000003}.
- Reset cases: rst asserted after the L word with 1 frame buffered → frame_valid=0, overflow_cnt=0; the following R word is discarded with a sync_err pulse. rx_dvalid held high across reset release → no event.
